// File: rtl/control_unit_if.sv
// Instruction-in / control-out bundle between the instruction source and the control unit.
interface control_unit_if;
    logic [7:0] inst;
    logic [3:0] aluSel;
    logic [2:0] regInSel;
    logic [2:0] regOutSel;
    logic       regInEn;
    logic       regOutEn;
    logic       genConst;
    logic       loadAddr;

    modport master (
        output inst,
        input  aluSel, regInSel, regOutSel, regInEn, regOutEn, genConst, loadAddr
    );

    modport slave (
        input  inst,
        output aluSel, regInSel, regOutSel, regInEn, regOutEn, genConst, loadAddr
    );
endinterface

// File: rtl/control_unit.sv
// Registered instruction decoder for the 8-bit datapath; ALU instructions are
// only decoded when CONTROL_UNIT_ALU_EN is defined, otherwise 0x80-0xFF act as NOP.
module control_unit (
    input  logic          clk,
    input  logic          rst,
    control_unit_if.slave bus
);

    // Every output starts from zero each cycle, so undecoded opcodes fall out as NOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.aluSel    <= 4'b0000;
            bus.regInSel  <= 3'b000;
            bus.regOutSel <= 3'b000;
            bus.regInEn   <= 1'b0;
            bus.regOutEn  <= 1'b0;
            bus.genConst  <= 1'b0;
            bus.loadAddr  <= 1'b0;
        end else begin
            bus.aluSel    <= 4'b0000;
            bus.regInSel  <= 3'b000;
            bus.regOutSel <= 3'b000;
            bus.regInEn   <= 1'b0;
            bus.regOutEn  <= 1'b0;
            bus.genConst  <= 1'b0;
            bus.loadAddr  <= 1'b0;
            if (bus.inst[7]) begin
`ifdef CONTROL_UNIT_ALU_EN
                bus.aluSel    <= bus.inst[6:3];
                bus.regOutSel <= bus.inst[2:0];
                bus.regOutEn  <= 1'b1;
                bus.regInEn   <= 1'b1;
`endif
            end else begin
                case (bus.inst[7:3])
                    5'b00001: begin
                        bus.regOutSel <= bus.inst[2:0];
                        bus.regInEn   <= 1'b1;
                        bus.regOutEn  <= 1'b1;
                    end
                    5'b00010: begin
                        bus.regInSel <= bus.inst[2:0];
                        bus.regInEn  <= 1'b1;
                        bus.regOutEn <= 1'b1;
                    end
                    // The constant generator owns the bus here, so no register drives it.
                    5'b00011: begin
                        bus.genConst <= 1'b1;
                        bus.regInSel <= bus.inst[2:0];
                        bus.regInEn  <= 1'b1;
                    end
                    5'b00100: begin
                        bus.loadAddr  <= 1'b1;
                        bus.regOutSel <= bus.inst[2:0];
                        bus.regOutEn  <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: driver queues expected decodes, monitor
// compares one cycle later. Honors CONTROL_UNIT_ALU_EN the same way as the design.
module tb_control_unit;

    typedef struct packed {
        logic [3:0] aluSel;
        logic [2:0] regInSel;
        logic [2:0] regOutSel;
        logic       regInEn;
        logic       regOutEn;
        logic       genConst;
        logic       loadAddr;
    } ctrl_t;

    typedef struct {
        ctrl_t ctrl;
        string name;
    } sb_entry_t;

    logic clk;
    logic rst;
    control_unit_if bus ();

    sb_entry_t sb[$];
    int checks = 0;
    int errors = 0;

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode written from the instruction table by opcode ranges.
    function automatic ctrl_t model(input logic r, input logic [7:0] i);
        ctrl_t e;
        e = '0;
        if (!r) begin
            if (i >= 8'h80) begin
`ifdef CONTROL_UNIT_ALU_EN
                e.aluSel    = i[6:3];
                e.regOutSel = i[2:0];
                e.regOutEn  = 1'b1;
                e.regInEn   = 1'b1;
`endif
            end else if (i >= 8'h08 && i <= 8'h0F) begin
                e.regOutSel = i[2:0];
                e.regInEn   = 1'b1;
                e.regOutEn  = 1'b1;
            end else if (i >= 8'h10 && i <= 8'h17) begin
                e.regInSel = i[2:0];
                e.regInEn  = 1'b1;
                e.regOutEn = 1'b1;
            end else if (i >= 8'h18 && i <= 8'h1F) begin
                e.genConst = 1'b1;
                e.regInSel = i[2:0];
                e.regInEn  = 1'b1;
            end else if (i >= 8'h20 && i <= 8'h27) begin
                e.loadAddr  = 1'b1;
                e.regOutSel = i[2:0];
                e.regOutEn  = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic r, input logic [7:0] i, input string name);
        sb_entry_t ent;
        rst      = r;
        bus.inst = i;
        ent.ctrl = model(r, i);
        ent.name = name;
        sb.push_back(ent);
        @(negedge clk);
    endtask

    task automatic checkOutput();
        sb_entry_t ent;
        ctrl_t     got;
        ent = sb.pop_front();
        got = '{bus.aluSel, bus.regInSel, bus.regOutSel, bus.regInEn,
                bus.regOutEn, bus.genConst, bus.loadAddr};
        checks++;
        if (got !== ent.ctrl) begin
            errors++;
            $display("[TB] FAIL %s: got alu=%b in=%b out=%b inEn=%b outEn=%b gc=%b la=%b, expected alu=%b in=%b out=%b inEn=%b outEn=%b gc=%b la=%b",
                     ent.name, got.aluSel, got.regInSel, got.regOutSel, got.regInEn,
                     got.regOutEn, got.genConst, got.loadAddr,
                     ent.ctrl.aluSel, ent.ctrl.regInSel, ent.ctrl.regOutSel, ent.ctrl.regInEn,
                     ent.ctrl.regOutEn, ent.ctrl.genConst, ent.ctrl.loadAddr);
        end
        checks++;
        if (got.genConst === 1'b1 && got.regOutEn === 1'b1) begin
            errors++;
            $display("[TB] FAIL %s bus_contention: genConst=%b regOutEn=%b, required not both 1",
                     ent.name, got.genConst, got.regOutEn);
        end
    endtask

    // Monitor: outputs settle just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) checkOutput();
        end
    end

    initial begin
        logic [7:0] boundary [12];
        logic [7:0] ri;
        boundary = '{8'h07, 8'h08, 8'h0F, 8'h10, 8'h17, 8'h18,
                     8'h1F, 8'h20, 8'h27, 8'h7F, 8'h80, 8'hFF};
        rst      = 1'b1;
        bus.inst = 8'hFF;

        applyStimulus(1'b1, 8'hFF, "reset");
        applyStimulus(1'b0, 8'h00, "nop");
        applyStimulus(1'b0, 8'h0B, "mov_r0_r3");
        applyStimulus(1'b0, 8'h1E, "ldc_r6");
        applyStimulus(1'b0, 8'h22, "lda_r2");
        applyStimulus(1'b0, 8'h9D, "alu_9d");
        applyStimulus(1'b0, 8'h28, "reserved_28");
        applyStimulus(1'b0, 8'h13, "mov_r3_r0");
        applyStimulus(1'b1, 8'h0B, "reset_priority");
        applyStimulus(1'b0, 8'h0B, "after_reset");
        foreach (boundary[k]) applyStimulus(1'b0, boundary[k], $sformatf("boundary_%02h", boundary[k]));

        for (int n = 0; n < 300; n++) begin
            ri = 8'($urandom_range(0, 255));
            applyStimulus(($urandom_range(0, 19) == 0), ri, $sformatf("rand_%0d_%02h", n, ri));
        end

        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
